reg_bank_ctrl: RTL and testbench

Arbitrated write controller for a bank of 16-bit registers. Several requesters share one write port through a valid/ready handshake and round-robin arbitration. A sequenced clear operation sweeps zero through the bank one register per cycle. Two combinational read ports expose the bank to the datapath. The block sits between the execution units that produce results and the general-purpose register storage.

---
 rtl/reg_bank_pkg.sv | 16 +
 rtl/reg_bank_ctrl_rr_arbiter.sv | 35 +++
 rtl/reg_bank_ctrl.sv | 153 +++++++++++++++
 tb/tb_reg_bank_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared definitions for the arbitrated register-bank write controller:
// data word type, controller state encoding and default bank geometry.
package reg_bank_pkg;

    localparam int DATA_W   = 16;
    localparam int DEF_NREQ = 4;
    localparam int DEF_NREG = 8;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/reg_bank_ctrl_rr_arbiter.sv
// Combinational round-robin picker. Starting at ptr and wrapping, it grants
// the first asserted request. The pointer register lives in the parent.
module rr_arbiter
    import reg_bank_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx,
    output logic            grant_valid
);

    // Scan requesters in priority order ptr, ptr+1, ... and take the first hit.
    always_comb begin : pick
        int cand;
        // NOTE: every output gets a default before any branch, so no path can
        // leave a value unassigned and infer a latch.
        cand        = 0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!grant_valid && req[cand[PW-1:0]]) begin
                grant_valid             = 1'b1;
                grant[cand[PW-1:0]]     = 1'b1;
                grant_idx               = cand[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/reg_bank_ctrl.sv
// Arbitrated write controller for a bank of 16-bit registers.
// Requesters share one write port through valid/ready and round-robin
// arbitration. A clear sweep zeroes one register per cycle. Two
// combinational read ports expose the bank.
// Optional feature: define REG_BANK_CTRL_BYPASS_EN for read-during-write
// forwarding (and zero for the register being cleared).
module reg_bank_ctrl
    import reg_bank_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    parameter  int NREG = DEF_NREG,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                   CLK,
    input  logic                   RES,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*AW-1:0]     req_addr,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    input  logic                   clr_start,
    output logic                   clr_busy,
    output logic                   clr_done,
    input  logic [AW-1:0]          rd_addr_a,
    input  logic [AW-1:0]          rd_addr_b,
    output logic [DATA_W-1:0]      rd_data_a,
    output logic [DATA_W-1:0]      rd_data_b
);

    localparam int PW = $clog2(NREQ);

    state_e        state_q, state_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;
    logic          clr_done_q, clr_done_d;
    word_t         bank_q [NREG];
    word_t         bank_d [NREG];

    logic [AW-1:0] req_reg  [NREQ];
    word_t         req_word [NREQ];

    logic [NREQ-1:0] arb_grant;
    logic [PW-1:0]   arb_idx;
    logic            arb_valid;

    logic          grant_en;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    word_t         wr_data;

    // Split the packed request buses into per-requester address and data.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_reg[i]  = req_addr[i*AW +: AW];
            req_word[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req         (req_valid),
        .ptr         (rr_ptr_q),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    // Grants only in IDLE, and a starting clear wins over any request.
    always_comb begin
        grant_en  = (state_q == IDLE) && !clr_start;
        req_ready = grant_en ? arb_grant : '0;
        wr_en     = grant_en && arb_valid;
        wr_addr   = req_reg[arb_idx];
        wr_data   = req_word[arb_idx];
    end

    // Next-state logic: sequencing, pointer advance and the single bank write.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        clr_idx_d  = clr_idx_q;
        clr_done_d = 1'b0;
        bank_d     = bank_q;
        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d   = CLEAR;
                    clr_idx_d = '0;
                end else if (wr_en) begin
                    bank_d[wr_addr] = wr_data;
                    rr_ptr_d = (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + PW'(1);
                end
            end
            CLEAR: begin
                bank_d[clr_idx_q] = '0;
                clr_idx_d         = clr_idx_q + AW'(1);
                if (clr_idx_q == AW'(NREG - 1)) begin
                    state_d    = IDLE;
                    clr_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any sweep and zeroes the whole bank.
    always_ff @(posedge CLK or posedge RES) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (RES) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            clr_idx_q  <= '0;
            clr_done_q <= 1'b0;
            // NOTE: the bank is architecturally zero after reset, so it is
            // built from resettable flops rather than an un-reset RAM.
            for (int r = 0; r < NREG; r++) begin
                bank_q[r] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            clr_idx_q  <= clr_idx_d;
            clr_done_q <= clr_done_d;
            for (int r = 0; r < NREG; r++) begin
                bank_q[r] <= bank_d[r];
            end
        end
    end

    assign clr_busy = (state_q == CLEAR);
    assign clr_done = clr_done_q;

    // Read ports: bank contents, optionally forwarding the write in flight.
    always_comb begin
        rd_data_a = bank_q[rd_addr_a];
        rd_data_b = bank_q[rd_addr_b];
`ifdef REG_BANK_CTRL_BYPASS_EN
        if (wr_en && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
        end else if ((state_q == CLEAR) && (clr_idx_q == rd_addr_a)) begin
            rd_data_a = '0;
        end
        if (wr_en && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
        end else if ((state_q == CLEAR) && (clr_idx_q == rd_addr_b)) begin
            rd_data_b = '0;
        end
`endif
    end

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Scoreboard bench for reg_bank_ctrl. A behavioural model predicts each
// cycle's grant, read data and clear flags; a negedge monitor compares.
module tb_reg_bank_ctrl;

    localparam int NREQ = 4;
    localparam int NREG = 8;
    localparam int AW   = 3;

    logic                 CLK = 1'b0;
    logic                 RES;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*16-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 clr_start;
    logic                 clr_busy;
    logic                 clr_done;
    logic [AW-1:0]        rd_addr_a;
    logic [AW-1:0]        rd_addr_b;
    logic [15:0]          rd_data_a;
    logic [15:0]          rd_data_b;

    always #5 CLK = ~CLK;

    reg_bank_ctrl #(
        .NREQ (NREQ),
        .NREG (NREG)
    ) dut (
        .CLK       (CLK),
        .RES       (RES),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b)
    );

    typedef struct {
        logic [NREQ-1:0] ready;
        logic [15:0]     rda;
        logic [15:0]     rdb;
        logic            busy;
        logic            done;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    logic [15:0] m_bank [NREG];
    int          m_rr;
    bit          m_clear;
    int          m_cidx;
    bit          m_done;

    // Requester side: a pending request holds until it is accepted
    bit          p_valid [NREQ];
    int          p_addr  [NREQ];
    logic [15:0] p_data  [NREQ];
    int          rd_a, rd_b;
    int          last_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare whatever the DUT presents this cycle with the prediction.
    always @(negedge CLK) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("req_ready", 32'(req_ready), 32'(e.ready));
            check("rd_data_a", 32'(rd_data_a), 32'(e.rda));
            check("rd_data_b", 32'(rd_data_b), 32'(e.rdb));
            check("clr_busy",  32'(clr_busy),  32'(e.busy));
            check("clr_done",  32'(clr_done),  32'(e.done));
        end
    end

    function automatic logic [15:0] read_model(input int a, input int g);
`ifdef REG_BANK_CTRL_BYPASS_EN
        if (g >= 0 && p_addr[g] == a) return p_data[g];
        if (m_clear && m_cidx == a) return 16'h0000;
`endif
        return m_bank[a];
    endfunction

    function automatic bit any_pending();
        for (int i = 0; i < NREQ; i++) if (p_valid[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic set_req(input int i, input int a, input logic [15:0] d);
        p_valid[i] = 1'b1;
        p_addr[i]  = a;
        p_data[i]  = d;
    endtask

    // One clock cycle: drive inputs, predict outputs, then advance the model.
    task automatic cycle(input bit res, input bit clr);
        int   g;
        exp_t e;
        RES       = res;
        clr_start = clr;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]         = p_valid[i];
            req_addr[i*AW +: AW] = AW'(p_addr[i]);
            req_data[i*16 +: 16] = p_data[i];
        end
        rd_addr_a = AW'(rd_a);
        rd_addr_b = AW'(rd_b);
        if (res) begin
            for (int r = 0; r < NREG; r++) m_bank[r] = 16'h0000;
            m_rr = 0; m_clear = 1'b0; m_cidx = 0; m_done = 1'b0;
        end
        g = -1;
        if (!m_clear && !clr) begin
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (m_rr + k) % NREQ;
                if (g < 0 && p_valid[c]) g = c;
            end
        end
        e.ready = '0;
        if (g >= 0) e.ready[g] = 1'b1;
        e.rda  = read_model(rd_a, g);
        e.rdb  = read_model(rd_b, g);
        e.busy = m_clear;
        e.done = m_done;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        if (!res) begin
            m_done = 1'b0;
            if (m_clear) begin
                m_bank[m_cidx] = 16'h0000;
                m_cidx++;
                if (m_cidx == NREG) begin
                    m_clear = 1'b0;
                    m_done  = 1'b1;
                end
            end else if (clr) begin
                m_clear = 1'b1;
                m_cidx  = 0;
            end else if (g >= 0) begin
                m_bank[p_addr[g]] = p_data[g];
                m_rr              = (g + 1) % NREQ;
                p_valid[g]        = 1'b0;
                last_addr         = p_addr[g];
            end
        end
    endtask

    task automatic drain();
        while (any_pending()) cycle(1'b0, 1'b0);
    endtask

    task automatic fill_const(input logic [15:0] v);
        for (int k = 0; k < NREG; k++) begin
            while (p_valid[k % NREQ]) cycle(1'b0, 1'b0);
            set_req(k % NREQ, k, v);
        end
        drain();
    endtask

    task automatic run_rr(input int n, input logic [15:0] base);
        int cnt = 0;
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!p_valid[i]) begin
                    set_req(i, cnt % NREG, base + 16'(cnt));
                    cnt++;
                end
            end
            rd_a = last_addr;
            rd_b = $urandom_range(NREG - 1);
            cycle(1'b0, 1'b0);
        end
    endtask

    task automatic sweep_reads();
        for (int k = 0; k < NREG / 2; k++) begin
            rd_a = k;
            rd_b = k + NREG / 2;
            cycle(1'b0, 1'b0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        RES = 1'b1; clr_start = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
        rd_addr_a = '0; rd_addr_b = '0;
        rd_a = 0; rd_b = 0; last_addr = 0;
        for (int i = 0; i < NREQ; i++) begin
            p_valid[i] = 1'b0; p_addr[i] = 0; p_data[i] = 16'h0000;
        end
        @(posedge CLK);
        #1;
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);

        // Load nonzero data, then reset mid-cycle with requesters 0 and 2 valid
        fill_const(16'h7777);
        set_req(0, 1, 16'hAAAA);
        set_req(2, 2, 16'hBBBB);
        rd_a = 1; rd_b = 3;
        cycle(1'b1, 1'b0);
        sweep_reads();

        // Round-robin with all four requesters continuously valid
        run_rr(8, 16'h1000);
        drain();

        // Sparse: move the pointer to 2, then requesters 0 and 1
        set_req(1, 6, 16'h2222);
        cycle(1'b0, 1'b0);
        set_req(0, 3, 16'h3333);
        set_req(1, 4, 16'h4444);
        rd_a = 3; rd_b = 4;
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);

        // Clear sweep against four held requests
        fill_const(16'hA5A5);
        for (int i = 0; i < NREQ; i++) set_req(i, i, 16'hC000 + 16'(i));
        rd_a = 0; rd_b = NREG - 1;
        cycle(1'b0, 1'b1);
        for (int c = 0; c < NREG + 2; c++) begin
            rd_a = c % NREG;
            rd_b = (c + 1) % NREG;
            cycle(1'b0, 1'b0);
        end
        drain();
        sweep_reads();

        // Reset in the middle of a sweep
        fill_const(16'h5A5A);
        cycle(1'b0, 1'b1);
        repeat (3) cycle(1'b0, 1'b0);
        rd_a = 5; rd_b = 7;
        cycle(1'b1, 1'b0);
        for (int c = 0; c < NREG + 3; c++) begin
            rd_a = c % NREG;
            rd_b = NREG - 1 - (c % NREG);
            cycle(1'b0, 1'b0);
        end

        // Read-during-write on r5
        set_req(0, 5, 16'h0BAD);
        drain();
        set_req(1, 5, 16'h1234);
        rd_a = 5; rd_b = 5;
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);

        // Randomised traffic with occasional clears
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!p_valid[i] && $urandom_range(1) == 1)
                    set_req(i, $urandom_range(NREG - 1), 16'($urandom));
            end
            rd_a = $urandom_range(NREG - 1);
            rd_b = $urandom_range(NREG - 1);
            if ($urandom_range(3) == 0) rd_a = p_addr[$urandom_range(NREQ - 1)];
            cycle(1'b0, $urandom_range(19) == 0);
        end

        repeat (2) @(negedge CLK);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
